sp_ram_arb_ctrl: RTL and testbench

- Two-port round-robin arbiter and clear sequencer placed in front of one single-port SRAM wrapper instance.
- Shares the macro between two requesters (A, typically core; B, typically DMA/debug) using a req/gnt/rvalid protocol.
- Zero-fills the whole array after reset, and on command, before any requester is granted.
- Drives the wrapper's en/addr/wdata/we/be pins; `ram_ctrl` is not touched.

---
 rtl/sp_ram_arb_ctrl.sv | 145 ++++++++++++++
 tb/tb_sp_ram_arb_ctrl.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_ram_arb_ctrl.sv
// sp_ram_arb_ctrl
//   Round-robin arbiter that shares one single-port SRAM wrapper between two
//   requesters (A and B) using a req/gnt/rvalid handshake. It also includes a
//   zero-fill sequencer that writes 0 to every word after reset (when
//   CLEAR_ON_RESET=1) and whenever clr_start_i is pulsed in RUN.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   clr_start_i         one-cycle pulse requesting a full-array zero fill
//   clr_busy_o          high while the zero fill is running
//   {a,b}_req_i/gnt_o   request / combinational grant; transfer when both high
//   {a,b}_addr_i, _we_i, _be_i, _wdata_i   access payload
//   {a,b}_rvalid_o      read data valid, one cycle after a read grant
//   {a,b}_rdata_o       read data (both wired to ram_rdata_i)
//   ram_en_o, ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o, ram_rdata_i
//                       SRAM wrapper pins
module sp_ram_arb_ctrl #(
  parameter int unsigned DW             = 32,
  parameter int unsigned AW             = 10,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_start_i,
  output logic            clr_busy_o,
  input  logic            a_req_i,
  output logic            a_gnt_o,
  input  logic [AW-1:0]   a_addr_i,
  input  logic            a_we_i,
  input  logic [DW/8-1:0] a_be_i,
  input  logic [DW-1:0]   a_wdata_i,
  output logic            a_rvalid_o,
  output logic [DW-1:0]   a_rdata_o,
  input  logic            b_req_i,
  output logic            b_gnt_o,
  input  logic [AW-1:0]   b_addr_i,
  input  logic            b_we_i,
  input  logic [DW/8-1:0] b_be_i,
  input  logic [DW-1:0]   b_wdata_i,
  output logic            b_rvalid_o,
  output logic [DW-1:0]   b_rdata_o,
  output logic            ram_en_o,
  output logic [AW-1:0]   ram_addr_o,
  output logic            ram_we_o,
  output logic [DW/8-1:0] ram_be_o,
  output logic [DW-1:0]   ram_wdata_o,
  input  logic [DW-1:0]   ram_rdata_i
);

  localparam int unsigned BW = DW / 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam state_e        RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
  localparam logic [AW-1:0] LAST_ADDR   = {AW{1'b1}};

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  // Priority pointer: 0 = A wins a tie, 1 = B wins a tie.
  logic          ptr_q, ptr_d;

  // State, clear counter, priority pointer and read-valid registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RESET_STATE;
      cnt_q      <= '0;
      ptr_q      <= 1'b0;
      a_rvalid_o <= 1'b0;
      b_rvalid_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      a_rvalid_o <= a_gnt_o & ~a_we_i;
      b_rvalid_o <= b_gnt_o & ~b_we_i;
    end
  end

  // Next state, arbitration and SRAM pin mux.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    a_gnt_o     = 1'b0;
    b_gnt_o     = 1'b0;
    ram_en_o    = 1'b0;
    ram_addr_o  = '0;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    ram_wdata_o = '0;
    clr_busy_o  = (state_q == ST_CLEAR);

    if (rst) begin
      // Keep the SRAM and requesters quiet while reset is held.
      clr_busy_o = CLEAR_ON_RESET;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          ram_en_o    = 1'b1;
          ram_we_o    = 1'b1;
          ram_be_o    = {BW{1'b1}};
          ram_addr_o  = cnt_q;
          // Wraps to 0 after the last word, leaving the counter ready for the next clear.
          cnt_d       = cnt_q + AW'(1);
          if (cnt_q == LAST_ADDR) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          a_gnt_o = a_req_i & (~b_req_i | ~ptr_q);
          b_gnt_o = b_req_i & (~a_req_i | ptr_q);
          if (a_gnt_o) begin
            ptr_d       = 1'b1;
            ram_addr_o  = a_addr_i;
            ram_we_o    = a_we_i;
            ram_be_o    = a_be_i;
            ram_wdata_o = a_wdata_i;
          end else if (b_gnt_o) begin
            ptr_d       = 1'b0;
            ram_addr_o  = b_addr_i;
            ram_we_o    = b_we_i;
            ram_be_o    = b_be_i;
            ram_wdata_o = b_wdata_i;
          end
          ram_en_o = a_gnt_o | b_gnt_o;
          if (clr_start_i) begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = RESET_STATE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign a_rdata_o = ram_rdata_i;
  assign b_rdata_o = ram_rdata_i;

endmodule

// File: tb/tb_sp_ram_arb_ctrl.sv
// Bench for sp_ram_arb_ctrl (DW=32, AW=4). It uses a behavioural SRAM and a
// reference memory. Expected read data is queued per port when a read grant
// is expected, and is popped when the matching rvalid appears.
module tb_sp_ram_arb_ctrl;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 4;
  localparam int unsigned BW    = DW / 8;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr_start;
  logic          clr_busy;
  logic          a_req, a_gnt, a_we, a_rvalid;
  logic [AW-1:0] a_addr;
  logic [BW-1:0] a_be;
  logic [DW-1:0] a_wdata, a_rdata;
  logic          b_req, b_gnt, b_we, b_rvalid;
  logic [AW-1:0] b_addr;
  logic [BW-1:0] b_be;
  logic [DW-1:0] b_wdata, b_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [BW-1:0] ram_be;
  logic [DW-1:0] ram_wdata, ram_rdata;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          a_q[$];
  exp_t          b_q[$];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] sram    [DEPTH];
  int            cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  sp_ram_arb_ctrl #(.DW(DW), .AW(AW), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst), .clr_start_i(clr_start), .clr_busy_o(clr_busy),
    .a_req_i(a_req), .a_gnt_o(a_gnt), .a_addr_i(a_addr), .a_we_i(a_we),
    .a_be_i(a_be), .a_wdata_i(a_wdata), .a_rvalid_o(a_rvalid), .a_rdata_o(a_rdata),
    .b_req_i(b_req), .b_gnt_o(b_gnt), .b_addr_i(b_addr), .b_we_i(b_we),
    .b_be_i(b_be), .b_wdata_i(b_wdata), .b_rvalid_o(b_rvalid), .b_rdata_o(b_rdata),
    .ram_en_o(ram_en), .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_be_o(ram_be),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port SRAM with byte enables and one-cycle read latency.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int k = 0; k < BW; k++)
          if (ram_be[k]) sram[ram_addr][8*k +: 8] <= ram_wdata[8*k +: 8];
      end else begin
        ram_rdata <= sram[ram_addr];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ref_write(input logic [AW-1:0] addr, input logic [BW-1:0] be,
                           input logic [DW-1:0] data);
    for (int k = 0; k < BW; k++)
      if (be[k]) ref_mem[addr][8*k +: 8] = data[8*k +: 8];
  endtask

  task automatic ref_clear();
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = '0;
  endtask

  task automatic push_a(input logic [DW-1:0] data);
    exp_t e;
    e.data = data;
    e.due  = cyc + 1;
    a_q.push_back(e);
  endtask

  task automatic push_b(input logic [DW-1:0] data);
    exp_t e;
    e.data = data;
    e.due  = cyc + 1;
    b_q.push_back(e);
  endtask

  // Scoreboard: match every rvalid against the queued expectation, in order and on time.
  task automatic scoreboard_monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (a_rvalid === 1'b1) begin
        n_checks++;
        if (a_q.size() == 0) begin
          n_fail++;
          $display("FAIL a_rvalid_unexpected: got rvalid=1 data=%h at cycle %0d, required none", a_rdata, cyc);
        end else begin
          e = a_q.pop_front();
          if (e.due !== cyc || a_rdata !== e.data) begin
            n_fail++;
            $display("FAIL a_read_return: got data=%h cycle=%0d, required data=%h cycle=%0d", a_rdata, cyc, e.data, e.due);
          end
        end
      end else if (a_q.size() != 0 && a_q[0].due <= cyc) begin
        n_checks++;
        n_fail++;
        e = a_q.pop_front();
        $display("FAIL a_rvalid_missing: got rvalid=%b at cycle %0d, required 1 with data=%h", a_rvalid, cyc, e.data);
      end
      if (b_rvalid === 1'b1) begin
        n_checks++;
        if (b_q.size() == 0) begin
          n_fail++;
          $display("FAIL b_rvalid_unexpected: got rvalid=1 data=%h at cycle %0d, required none", b_rdata, cyc);
        end else begin
          e = b_q.pop_front();
          if (e.due !== cyc || b_rdata !== e.data) begin
            n_fail++;
            $display("FAIL b_read_return: got data=%h cycle=%0d, required data=%h cycle=%0d", b_rdata, cyc, e.data, e.due);
          end
        end
      end else if (b_q.size() != 0 && b_q[0].due <= cyc) begin
        n_checks++;
        n_fail++;
        e = b_q.pop_front();
        $display("FAIL b_rvalid_missing: got rvalid=%b at cycle %0d, required 1 with data=%h", b_rvalid, cyc, e.data);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    #1;
    n_checks++;
    if (clr_busy !== 1'b1 || ram_en !== 1'b0 || a_gnt !== 1'b0 || b_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b en=%b agnt=%b bgnt=%b, required 1 0 0 0", clr_busy, ram_en, a_gnt, b_gnt);
    end
    ref_clear();
    a_req = 1'b1; a_addr = 4'd3; a_we = 1'b0;
    rst = 1'b0;
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_be !== 4'hF || ram_wdata !== '0 ||
          ram_addr !== AW'(i) || clr_busy !== 1'b1 || a_gnt !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_clear_cycle%0d: got en=%b we=%b be=%h wd=%h addr=%0d busy=%b agnt=%b, required 1 1 f 0 %0d 1 0",
                 i, ram_en, ram_we, ram_be, ram_wdata, ram_addr, clr_busy, a_gnt, i);
      end
      tick(); #1;
    end
    n_checks++;
    if (a_gnt !== 1'b1 || clr_busy !== 1'b0 || ram_addr !== 4'd3 || ram_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_grant: got agnt=%b busy=%b addr=%0d we=%b, required 1 0 3 0", a_gnt, clr_busy, ram_addr, ram_we);
    end
    push_a(ref_mem[3]);
    tick();
    a_req = 1'b0;
  endtask

  task automatic test_write_read();
    tick();
    a_req = 1'b1; a_we = 1'b1; a_addr = 4'd5; a_be = 4'hF; a_wdata = 32'hFFFF_FFFF;
    #1;
    n_checks++;
    if (a_gnt !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 4'd5 || ram_wdata !== 32'hFFFF_FFFF || ram_be !== 4'hF) begin
      n_fail++;
      $display("FAIL wr_full: got gnt=%b we=%b addr=%0d wd=%h be=%h, required 1 1 5 ffffffff f", a_gnt, ram_we, ram_addr, ram_wdata, ram_be);
    end
    ref_write(4'd5, 4'hF, 32'hFFFF_FFFF);
    tick();
    a_wdata = 32'h1234_5678; a_be = 4'b0011;
    #1;
    n_checks++;
    if (a_gnt !== 1'b1 || ram_be !== 4'b0011 || ram_wdata !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL wr_partial: got gnt=%b be=%h wd=%h, required 1 3 12345678", a_gnt, ram_be, ram_wdata);
    end
    ref_write(4'd5, 4'b0011, 32'h1234_5678);
    tick();
    a_we = 1'b0; a_be = 4'h0; a_wdata = '0;
    #1;
    n_checks++;
    if (a_gnt !== 1'b1 || ram_we !== 1'b0 || ram_en !== 1'b1 || ram_addr !== 4'd5) begin
      n_fail++;
      $display("FAIL rd_grant: got gnt=%b we=%b en=%b addr=%0d, required 1 0 1 5", a_gnt, ram_we, ram_en, ram_addr);
    end
    push_a(32'hFFFF_5678);
    tick();
    a_req = 1'b0;
    #1;
    n_checks++;
    if (ram_en !== 1'b0 || ram_addr !== '0 || ram_wdata !== '0 || ram_be !== '0 || ram_we !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_pins: got en=%b addr=%0d wd=%h be=%h we=%b, required all 0", ram_en, ram_addr, ram_wdata, ram_be, ram_we);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      tick();
      a_req = 1'b1; a_we = 1'b1; a_be = 4'hF; a_addr = AW'(i); a_wdata = 32'hC0DE_0000 | DW'(i * 17);
      #1;
      ref_write(AW'(i), 4'hF, a_wdata);
    end
    tick();
    a_req = 1'b0; a_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      b_req = 1'b1; b_we = 1'b0; b_addr = AW'(i);
      #1;
      n_checks++;
      if (b_gnt !== 1'b1 || a_gnt !== 1'b0 || ram_addr !== AW'(i)) begin
        n_fail++;
        $display("FAIL b2b_grant%0d: got bgnt=%b agnt=%b addr=%0d, required 1 0 %0d", i, b_gnt, a_gnt, ram_addr, i);
      end
      push_b(ref_mem[i]);
    end
    tick();
    b_req = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_contention();
    b_req = 1'b1; b_we = 1'b0; b_addr = 4'd1;
    #1;
    n_checks++;
    if (b_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL cont_prime: got bgnt=%b, required 1", b_gnt);
    end
    push_b(ref_mem[1]);
    tick();
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd2;
    b_addr = 4'd3;
    #1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin tick(); #1; end
      n_checks++;
      if (a_gnt !== (i % 2 == 0) || b_gnt !== (i % 2 == 1) ||
          ram_addr !== ((i % 2 == 0) ? 4'd2 : 4'd3)) begin
        n_fail++;
        $display("FAIL contention%0d: got agnt=%b bgnt=%b addr=%0d, required %b %b %0d",
                 i, a_gnt, b_gnt, ram_addr, (i % 2 == 0), (i % 2 == 1), (i % 2 == 0) ? 2 : 3);
      end
      if (i % 2 == 0) push_a(ref_mem[2]);
      else            push_b(ref_mem[3]);
    end
    tick();
    a_req = 1'b0; b_req = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_clear_cmd();
    a_req = 1'b1; a_we = 1'b1; a_addr = 4'd7; a_be = 4'hF; a_wdata = 32'hA5A5_A5A5;
    #1;
    n_checks++;
    if (a_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL clrcmd_write: got agnt=%b, required 1", a_gnt);
    end
    ref_write(4'd7, 4'hF, 32'hA5A5_A5A5);
    tick();
    a_req = 1'b0; a_we = 1'b0;
    b_req = 1'b1; b_we = 1'b0; b_addr = 4'd7; clr_start = 1'b1;
    #1;
    n_checks++;
    if (b_gnt !== 1'b1 || clr_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clrcmd_read_grant: got bgnt=%b busy=%b, required 1 0", b_gnt, clr_busy);
    end
    push_b(ref_mem[7]);
    ref_clear();
    tick();
    clr_start = 1'b0; b_req = 1'b0;
    a_req = 1'b1; a_addr = 4'd7;
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      if (i > 0) begin tick(); #1; end
      n_checks++;
      if (clr_busy !== 1'b1 || ram_en !== 1'b1 || ram_we !== 1'b1 || ram_wdata !== '0 ||
          ram_addr !== AW'(i) || a_gnt !== 1'b0 || b_gnt !== 1'b0) begin
        n_fail++;
        $display("FAIL clrcmd_cycle%0d: got busy=%b en=%b we=%b wd=%h addr=%0d agnt=%b bgnt=%b, required 1 1 1 0 %0d 0 0",
                 i, clr_busy, ram_en, ram_we, ram_wdata, ram_addr, a_gnt, b_gnt, i);
      end
    end
    tick(); #1;
    n_checks++;
    if (a_gnt !== 1'b1 || clr_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clrcmd_after: got agnt=%b busy=%b, required 1 0", a_gnt, clr_busy);
    end
    push_a(ref_mem[7]);
    tick();
    a_req = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_reset_mid_clear();
    clr_start = 1'b1;
    #1;
    n_checks++;
    if (clr_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midclr_start: got busy=%b, required 0", clr_busy);
    end
    ref_clear();
    tick();
    clr_start = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd9;
    b_req = 1'b1; b_we = 1'b0; b_addr = 4'd10;
    #1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin tick(); #1; end
      n_checks++;
      if (ram_addr !== AW'(i) || a_gnt !== 1'b0 || b_gnt !== 1'b0) begin
        n_fail++;
        $display("FAIL midclr_pre%0d: got addr=%0d agnt=%b bgnt=%b, required %0d 0 0", i, ram_addr, a_gnt, b_gnt, i);
      end
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (ram_en !== 1'b0 || clr_busy !== 1'b1 || a_gnt !== 1'b0 || b_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL midclr_rst: got en=%b busy=%b agnt=%b bgnt=%b, required 0 1 0 0", ram_en, clr_busy, a_gnt, b_gnt);
    end
    tick();
    rst = 1'b0;
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      if (i > 0) begin tick(); #1; end
      n_checks++;
      if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== AW'(i) || clr_busy !== 1'b1 ||
          a_gnt !== 1'b0 || b_gnt !== 1'b0) begin
        n_fail++;
        $display("FAIL midclr_restart%0d: got en=%b we=%b addr=%0d busy=%b agnt=%b bgnt=%b, required 1 1 %0d 1 0 0",
                 i, ram_en, ram_we, ram_addr, clr_busy, a_gnt, b_gnt, i);
      end
    end
    tick(); #1;
    n_checks++;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0 || clr_busy !== 1'b0 || ram_addr !== 4'd9) begin
      n_fail++;
      $display("FAIL midclr_ptr_reset: got agnt=%b bgnt=%b busy=%b addr=%0d, required 1 0 0 9", a_gnt, b_gnt, clr_busy, ram_addr);
    end
    push_a(ref_mem[9]);
    tick();
    a_req = 1'b0;
    #1;
    n_checks++;
    if (b_gnt !== 1'b1 || ram_addr !== 4'd10) begin
      n_fail++;
      $display("FAIL midclr_b_after: got bgnt=%b addr=%0d, required 1 10", b_gnt, ram_addr);
    end
    push_b(ref_mem[10]);
    tick();
    b_req = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    rst = 1'b1; clr_start = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_be = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_be = '0; b_wdata = '0;
    fork
      scoreboard_monitor();
    join_none
    test_reset();
    test_write_read();
    test_back_to_back();
    test_contention();
    test_clear_cmd();
    test_reset_mid_clear();
    repeat (3) tick();
    n_checks++;
    if (a_q.size() != 0 || b_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d/%0d reads outstanding, required 0/0", a_q.size(), b_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
